// File: rtl/rob_multi_commit.sv
//==============================================================================
// Module      : rob_multi_commit
// Description : Reorder buffer with in-order multi-slot retirement, several
//               completion ports, exception and external flush.
//               Optional ROB_TRACE_EN builds per-entry PC storage/commit_pc_o.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rob_multi_commit #(
    parameter int ROB_ENTRIES    = 8,
    parameter int ENTRY_WIDTH    = $clog2(ROB_ENTRIES),
    parameter int COMMIT_WIDTH   = 2,
    parameter int CMPL_PORTS     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               alloc_valid_i,
    output logic                               alloc_ready_o,
    input  logic                               alloc_is_wb_i,
    input  logic [REGISTER_WIDTH-1:0]          alloc_reg_id_i,
    input  logic [ADDR_WIDTH-1:0]              alloc_pc_i,
    output logic [ENTRY_WIDTH-1:0]             alloc_idx_o,
    input  logic [CMPL_PORTS-1:0]              cmpl_valid_i,
    input  logic [CMPL_PORTS*ENTRY_WIDTH-1:0]  cmpl_idx_i,
    input  logic [CMPL_PORTS-1:0]              cmpl_excp_i,
    input  logic [CMPL_PORTS*DATA_WIDTH-1:0]   cmpl_data_i,
    input  logic                               flush_i,
    output logic [COMMIT_WIDTH-1:0]            commit_valid_o,
    output logic [COMMIT_WIDTH-1:0]            commit_is_wb_o,
    output logic [COMMIT_WIDTH*REGISTER_WIDTH-1:0] commit_reg_id_o,
    output logic [COMMIT_WIDTH*DATA_WIDTH-1:0] commit_data_o,
    output logic                               excp_valid_o,
    output logic [ENTRY_WIDTH-1:0]             excp_idx_o,
    output logic [ENTRY_WIDTH:0]               count_o,
    output logic                               empty_o
`ifdef ROB_TRACE_EN
    ,
    output logic [COMMIT_WIDTH*ADDR_WIDTH-1:0] commit_pc_o
`endif
);

    localparam logic [ENTRY_WIDTH:0] c_full_count = (ENTRY_WIDTH+1)'(ROB_ENTRIES);
    localparam logic [ENTRY_WIDTH:0] c_one_count  = (ENTRY_WIDTH+1)'(1);

    logic [ROB_ENTRIES-1:0]    r_occ;
    logic [ROB_ENTRIES-1:0]    r_done;
    logic [ROB_ENTRIES-1:0]    r_excp;
    logic [ROB_ENTRIES-1:0]    r_wb;
    logic [REGISTER_WIDTH-1:0] r_reg_id [ROB_ENTRIES];
    logic [DATA_WIDTH-1:0]     r_data   [ROB_ENTRIES];
`ifdef ROB_TRACE_EN
    logic [ADDR_WIDTH-1:0]     r_pc     [ROB_ENTRIES];
`else
    logic                      w_unused_pc;
    assign w_unused_pc = ^alloc_pc_i;
`endif

    logic [ENTRY_WIDTH-1:0]    r_head;
    logic [ENTRY_WIDTH-1:0]    r_tail;
    logic [ENTRY_WIDTH:0]      r_count;

    logic [ENTRY_WIDTH-1:0]    w_slot_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]   w_slot_valid;
    logic [ENTRY_WIDTH:0]      w_retire_cnt;
    logic                      w_chain;
    logic                      w_excp_valid;
    logic [ENTRY_WIDTH-1:0]    w_excp_idx;
    logic                      w_flush;
    logic                      w_alloc;

    generate
        for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot_idx
            assign w_slot_idx[k] = r_head + ENTRY_WIDTH'(k);
        end
    endgenerate

    // A slot retires only if every older slot retired and none of them excepted.
    always_comb begin
        w_chain         = 1'b1;
        w_slot_valid    = '0;
        w_retire_cnt    = '0;
        w_excp_valid    = 1'b0;
        w_excp_idx      = '0;
        commit_is_wb_o  = '0;
        commit_reg_id_o = '0;
        commit_data_o   = '0;
`ifdef ROB_TRACE_EN
        commit_pc_o     = '0;
`endif
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (w_chain && r_occ[w_slot_idx[k]] && r_done[w_slot_idx[k]]) begin
                w_slot_valid[k] = 1'b1;
                w_retire_cnt    = w_retire_cnt + c_one_count;
                commit_is_wb_o[k] = r_wb[w_slot_idx[k]] & ~r_excp[w_slot_idx[k]];
                commit_reg_id_o[k*REGISTER_WIDTH +: REGISTER_WIDTH] = r_reg_id[w_slot_idx[k]];
                commit_data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_data[w_slot_idx[k]];
`ifdef ROB_TRACE_EN
                commit_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH] = r_pc[w_slot_idx[k]];
`endif
                if (r_excp[w_slot_idx[k]]) begin
                    w_excp_valid = 1'b1;
                    w_excp_idx   = w_slot_idx[k];
                    w_chain      = 1'b0;
                end
            end else begin
                w_chain = 1'b0;
            end
        end
    end

    assign commit_valid_o = w_slot_valid;
    assign excp_valid_o   = w_excp_valid;
    assign excp_idx_o     = w_excp_idx;
    assign count_o        = r_count;
    assign empty_o        = (r_count == '0);
    assign alloc_idx_o    = r_tail;
    assign w_flush        = flush_i | w_excp_valid;
    // Full check uses registered count only, so same-cycle retirement never frees a slot.
    assign alloc_ready_o  = (r_count < c_full_count) & ~w_flush;
    assign w_alloc        = alloc_valid_i & alloc_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ   <= '0;
            r_done  <= '0;
            r_excp  <= '0;
            r_wb    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                r_reg_id[i] <= '0;
                r_data[i]   <= '0;
`ifdef ROB_TRACE_EN
                r_pc[i]     <= '0;
`endif
            end
        end else if (w_flush) begin
            r_occ   <= '0;
            r_done  <= '0;
            r_excp  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int p = 0; p < CMPL_PORTS; p++) begin
                if (cmpl_valid_i[p] && r_occ[cmpl_idx_i[p*ENTRY_WIDTH +: ENTRY_WIDTH]]) begin
                    r_done[cmpl_idx_i[p*ENTRY_WIDTH +: ENTRY_WIDTH]] <= 1'b1;
                    r_excp[cmpl_idx_i[p*ENTRY_WIDTH +: ENTRY_WIDTH]] <= cmpl_excp_i[p];
                    r_data[cmpl_idx_i[p*ENTRY_WIDTH +: ENTRY_WIDTH]] <=
                        cmpl_data_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (w_slot_valid[k]) begin
                    r_occ[w_slot_idx[k]] <= 1'b0;
                end
            end
            if (w_alloc) begin
                r_occ[r_tail]    <= 1'b1;
                r_done[r_tail]   <= 1'b0;
                r_excp[r_tail]   <= 1'b0;
                r_wb[r_tail]     <= alloc_is_wb_i;
                r_reg_id[r_tail] <= alloc_reg_id_i;
`ifdef ROB_TRACE_EN
                r_pc[r_tail]     <= alloc_pc_i;
`endif
                r_tail           <= r_tail + ENTRY_WIDTH'(1);
            end
            r_head  <= r_head + w_retire_cnt[ENTRY_WIDTH-1:0];
            r_count <= r_count + {{ENTRY_WIDTH{1'b0}}, w_alloc} - w_retire_cnt;
        end
    end

endmodule

`default_nettype wire
